// File: rtl/regfile_pkg.sv
// Shared constants, sweep FSM encoding and address-width helper for the register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_pkg;

    localparam int RF_XLEN  = 32;
    localparam int RF_NREGS = 32;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_e;

    // Smallest width that can index n entries (ceil(log2(n))).
    function automatic int rf_addr_w(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write bits: set on issue, cleared by writeback, issue wins on collision.
// Latency: set/clear visible one cycle later; rd_pend is combinational from the stored bits.
// Backpressure: none; set/clear are ignored while run is low.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = RF_NREGS,
    parameter int NRD   = 2,
    parameter int NWR   = 2,
    parameter int AW    = rf_addr_w(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD-1:0]    rd_pend
);

    logic [NREGS-1:0] pend_q;
    logic [NREGS-1:0] pend_d;

    // Next pend vector: writebacks clear first so a same-cycle issue overrides them.
    always_comb begin
        pend_d = pend_q;
        if (run) begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j]) begin
                    pend_d[wr_addr[j*AW +: AW]] = 1'b0;
                end
            end
            if (iss_en) begin
                pend_d[iss_addr] = 1'b1;
            end
        end
        pend_d[0] = 1'b0;
    end

    // Pend register with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // Read-out muxes; forced low while the sweep is running.
    always_comb begin
        rd_pend = '0;
        for (int i = 0; i < NRD; i++) begin
            rd_pend[i] = run & pend_q[rd_addr[i*AW +: AW]];
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with optional write-to-read bypass, pending scoreboard and post-reset clear sweep.
// Latency: reads combinational; writes visible next cycle (same cycle with BYPASS=1); ready after NREGS-1 edges.
// Backpressure: none; all traffic before ready is discarded.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN   = RF_XLEN,
    parameter int NREGS  = RF_NREGS,
    parameter int NRD    = 2,
    parameter int NWR    = 2,
    parameter int BYPASS = 1,
    parameter int AW     = rf_addr_w(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    output logic                ready,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_pend,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr
);

    rf_state_e         state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [XLEN-1:0]   regs_q [NREGS];
    logic [XLEN-1:0]   regs_d [NREGS];
    logic              run;

    assign run   = (state_q == RF_RUN);
    assign ready = run;

    // Sweep FSM: walk idx from 1 to NREGS-1, then stay in RUN until reset.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (state_q == RF_CLEAR) begin
            idx_d = idx_q + AW'(1);
            if (idx_q == AW'(NREGS - 1)) begin
                state_d = RF_RUN;
            end
        end
    end

    // FSM state and sweep index, synchronous reset restarts the sweep at 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RF_CLEAR;
            idx_q   <= AW'(1);
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Array next state: sweep clears one entry per edge; in RUN the later port overwrites earlier ones.
    always_comb begin
        regs_d = regs_q;
        if (state_q == RF_CLEAR) begin
            regs_d[idx_q] = '0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && (wr_addr[j*AW +: AW] != '0)) begin
                    regs_d[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
                end
            end
        end
        regs_d[0] = '0;
    end

    // Array storage; contents are only meaningful once the sweep has finished.
    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    // Read muxes with optional same-cycle forwarding; highest-numbered matching write port wins.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NRD; i++) begin
            if (run && (rd_addr[i*AW +: AW] != '0)) begin
                rd_data[i*XLEN +: XLEN] = regs_q[rd_addr[i*AW +: AW]];
                if (BYPASS != 0) begin
                    for (int j = 0; j < NWR; j++) begin
                        if (wr_en[j] && (wr_addr[j*AW +: AW] == rd_addr[i*AW +: AW])) begin
                            rd_data[i*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
                        end
                    end
                end
            end
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .NWR   (NWR),
        .AW    (AW)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .rd_addr  (rd_addr),
        .rd_pend  (rd_pend)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: reset sweep, write/read, port priority, bypass on/off, scoreboard, CLEAR traffic.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled 1 unit later.
// Backpressure: n/a.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  rd_addr = '0;
    logic [1:0]  wr_en = '0;
    logic [9:0]  wr_addr = '0;
    logic [63:0] wr_data = '0;
    logic        iss_en = 1'b0;
    logic [4:0]  iss_addr = '0;

    logic        ready, ready_nb;
    logic [63:0] rd_data, rd_data_nb;
    logic [1:0]  rd_pend, rd_pend_nb;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    regfile_mp #(.BYPASS(1)) dut (
        .clk(clk), .rst(rst), .ready(ready),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_pend(rd_pend),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr)
    );

    regfile_mp #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .ready(ready_nb),
        .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_pend(rd_pend_nb),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic set_wr(input int j, input logic [4:0] a, input logic [31:0] d);
        wr_en[j]          = 1'b1;
        wr_addr[j*5 +: 5] = a;
        wr_data[j*32 +: 32] = d;
    endtask

    task automatic idle();
        wr_en  = '0;
        iss_en = 1'b0;
    endtask

    initial begin
        // Reset held for two edges.
        step();
        step();
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_rd0", rd_data[31:0], 32'd0);
        chk("rst_pend", {30'd0, rd_pend}, 32'd0);

        // Sweep: ready rises on exactly the 31st edge after release.
        rst = 1'b0;
        for (int e = 1; e <= 31; e++) begin
            step();
            chk($sformatf("sweep_ready_e%0d", e), {31'd0, ready}, (e == 31) ? 32'd1 : 32'd0);
        end
        chk("sweep_ready_nb", {31'd0, ready_nb}, 32'd1);

        // Every register reads zero after the sweep.
        for (int r = 0; r < 32; r++) begin
            set_rd(5'(r), 5'(31 - r));
            #1;
            chk($sformatf("clr_x%0d", r), rd_data[31:0], 32'd0);
            chk($sformatf("clr_p1_x%0d", 31 - r), rd_data[63:32], 32'd0);
            chk($sformatf("clr_nb_x%0d", r), rd_data_nb[31:0], 32'd0);
        end

        // Reset again at edge 10 of a new sweep, with traffic injected during CLEAR.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            step();
        end
        chk("mid_ready", {31'd0, ready}, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int e = 1; e <= 31; e++) begin
            if (e >= 15 && e <= 25) begin
                set_wr(0, 5'd4, 32'hFF);
                iss_en   = 1'b1;
                iss_addr = 5'd4;
                set_rd(5'd4, 5'd4);
                #1;
                chk("clear_rd_zero", rd_data[31:0], 32'd0);
                chk("clear_pend_zero", {31'd0, rd_pend[0]}, 32'd0);
            end else begin
                idle();
            end
            step();
            chk($sformatf("resweep_ready_e%0d", e), {31'd0, ready}, (e == 31) ? 32'd1 : 32'd0);
        end
        idle();
        set_rd(5'd4, 5'd4);
        #1;
        chk("clear_x4_data", rd_data[31:0], 32'd0);
        chk("clear_x4_pend", {31'd0, rd_pend[0]}, 32'd0);

        // Basic write/read on x5, bypass visible in the write cycle.
        set_wr(0, 5'd5, 32'hDEADBEEF);
        set_rd(5'd5, 5'd5);
        #1;
        chk("byp_x5", rd_data[31:0], 32'hDEADBEEF);
        chk("nobyp_x5_old", rd_data_nb[31:0], 32'd0);
        step();
        idle();
        #1;
        chk("x5_p0", rd_data[31:0], 32'hDEADBEEF);
        chk("x5_p1", rd_data[63:32], 32'hDEADBEEF);
        chk("x5_nb", rd_data_nb[63:32], 32'hDEADBEEF);

        // Writes to x0 are dropped, even on the bypass path.
        set_wr(0, 5'd0, 32'h1234);
        set_rd(5'd0, 5'd0);
        #1;
        chk("x0_byp", rd_data[31:0], 32'd0);
        step();
        idle();
        #1;
        chk("x0_after", rd_data[63:32], 32'd0);

        // Port conflict on x7: port 1 wins in array and on bypass.
        set_wr(0, 5'd7, 32'h1111);
        set_wr(1, 5'd7, 32'h2222);
        set_rd(5'd7, 5'd5);
        #1;
        chk("conf_byp", rd_data[31:0], 32'h2222);
        chk("conf_other", rd_data[63:32], 32'hDEADBEEF);
        step();
        idle();
        #1;
        chk("conf_x7", rd_data[31:0], 32'h2222);
        chk("conf_x7_nb", rd_data_nb[31:0], 32'h2222);

        // Bypass off: old value in write cycle, new value next cycle.
        set_wr(1, 5'd3, 32'hA);
        step();
        idle();
        set_wr(0, 5'd3, 32'hB);
        set_rd(5'd3, 5'd3);
        #1;
        chk("nb_x3_old", rd_data_nb[31:0], 32'hA);
        chk("byp_x3_new", rd_data[31:0], 32'hB);
        step();
        idle();
        #1;
        chk("nb_x3_new", rd_data_nb[31:0], 32'hB);

        // Scoreboard on x9.
        set_rd(5'd9, 5'd0);
        iss_en   = 1'b1;
        iss_addr = 5'd9;
        #1;
        chk("pend_x9_same", {31'd0, rd_pend[0]}, 32'd0);
        step();
        idle();
        #1;
        chk("pend_x9_set", {31'd0, rd_pend[0]}, 32'd1);
        chk("pend_x9_nb", {31'd0, rd_pend_nb[0]}, 32'd1);
        set_wr(0, 5'd9, 32'h99);
        iss_en   = 1'b1;
        iss_addr = 5'd9;
        step();
        idle();
        #1;
        chk("pend_x9_iss_wins", {31'd0, rd_pend[0]}, 32'd1);
        set_wr(1, 5'd9, 32'h9A);
        #1;
        chk("pend_x9_no_fwd", {31'd0, rd_pend[0]}, 32'd1);
        step();
        idle();
        #1;
        chk("pend_x9_clr", {31'd0, rd_pend[0]}, 32'd0);
        chk("x9_data", rd_data[31:0], 32'h9A);
        iss_en   = 1'b1;
        iss_addr = 5'd0;
        step();
        idle();
        set_rd(5'd9, 5'd0);
        #1;
        chk("pend_x0", {31'd0, rd_pend[1]}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
